// File: rtl/l2_lru_tracker_pkg.sv
// L2 cache controller shared types and constants used by the LRU rank tracker.
// Optional per-op counters in the tracker are controlled by L2_LRU_PERF_CNT_EN.
package l2cpkg;

  localparam int L2_INDEX_LENGTH = 4;
  localparam int L2_ASSOC        = 8;
  localparam int L2_LRU_LENGTH   = $clog2(L2_ASSOC);
  localparam int LRU             = 0;
  localparam int MRU             = L2_ASSOC - 1;

  typedef logic [L2_LRU_LENGTH-1:0]   TYP_RU_NUM;
  typedef logic [L2_INDEX_LENGTH-1:0] TYP_INDX;

  // Encoding 2'd3 is reserved and behaves as a no-op that still responds.
  typedef enum logic [1:0] {
    TOUCH  = 2'd0,
    VICTIM = 2'd1,
    INVAL  = 2'd2
  } TYP_LRU_OP;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } sweep_state_e;

endpackage

// File: rtl/l2_lru_tracker_update.sv
// Combinational rank update for one set: TOUCH promotes a way to MRU, INVAL
// demotes it to LRU, VICTIM reports the LRU way without changing ranks.
module l2_lru_update
  import l2cpkg::*;
#(
  parameter int ASSOC = L2_ASSOC
) (
  input  TYP_RU_NUM [ASSOC-1:0] ranks_i,
  input  TYP_LRU_OP             op,
  input  TYP_RU_NUM             way,
  output TYP_RU_NUM [ASSOC-1:0] ranks_o,
  output TYP_RU_NUM             victim
);

  localparam TYP_RU_NUM MRU_R = TYP_RU_NUM'(ASSOC - 1);
  localparam TYP_RU_NUM LRU_R = TYP_RU_NUM'(LRU);

  TYP_RU_NUM cur_rank;

  always_comb begin
    ranks_o  = ranks_i;
    victim   = '0;
    cur_rank = ranks_i[way];

    for (int i = 0; i < ASSOC; i++) begin
      if (ranks_i[i] == LRU_R) victim = TYP_RU_NUM'(i);
    end

    case (op)
      TOUCH: begin
        if (cur_rank != MRU_R) begin
          for (int i = 0; i < ASSOC; i++) begin
            if (ranks_i[i] > cur_rank) ranks_o[i] = ranks_i[i] - TYP_RU_NUM'(1);
          end
          ranks_o[way] = MRU_R;
        end
      end
      INVAL: begin
        if (cur_rank != LRU_R) begin
          for (int i = 0; i < ASSOC; i++) begin
            if (ranks_i[i] < cur_rank) ranks_o[i] = ranks_i[i] + TYP_RU_NUM'(1);
          end
          ranks_o[way] = LRU_R;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/l2_lru_tracker.sv
// Per-set LRU rank tracker with an init sweep after reset/clr.
// Define L2_LRU_PERF_CNT_EN to add saturating TOUCH/VICTIM counters.
module l2_lru_tracker
  import l2cpkg::*;
#(
  parameter int NUM_SETS = 2**L2_INDEX_LENGTH,
  parameter int ASSOC    = L2_ASSOC
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      req_valid,
  output logic      req_ready,
  input  TYP_LRU_OP req_op,
  input  TYP_INDX   req_indx,
  input  TYP_RU_NUM req_way,
  output logic      rsp_valid,
  output TYP_RU_NUM rsp_way,
  input  logic      clr,
  output logic      busy
`ifdef L2_LRU_PERF_CNT_EN
  ,
  output logic [31:0] touch_cnt,
  output logic [31:0] victim_cnt
`endif
);

  // state    | meaning
  // ST_IDLE  | ranks valid, requests accepted
  // ST_SWEEP | writing identity ranks to one set per cycle, requests held off

  typedef TYP_RU_NUM [ASSOC-1:0] set_ranks_t;

  localparam TYP_INDX LAST_IDX = TYP_INDX'(NUM_SETS - 1);

  sweep_state_e state_q, state_d;
  TYP_INDX      sweep_idx_q, sweep_idx_d;
  logic         sweep_wr;
  logic         accept;

  set_ranks_t rank_mem_q [NUM_SETS];
  set_ranks_t rank_mem_d [NUM_SETS];
  set_ranks_t init_ranks;
  set_ranks_t upd_ranks;
  TYP_RU_NUM  victim;

  logic      rsp_valid_q, rsp_valid_d;
  TYP_RU_NUM rsp_way_q, rsp_way_d;

  assign busy      = (state_q == ST_SWEEP);
  assign req_ready = !busy && !clr;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = rsp_valid_q;
  assign rsp_way   = rsp_way_q;

  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    sweep_wr    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr) begin
          state_d     = ST_SWEEP;
          sweep_idx_d = '0;
        end
      end
      ST_SWEEP: begin
        sweep_wr = 1'b1;
        if (clr) begin
          sweep_idx_d = '0;
        end else if (sweep_idx_q == LAST_IDX) begin
          state_d     = ST_IDLE;
          sweep_idx_d = '0;
        end else begin
          sweep_idx_d = sweep_idx_q + TYP_INDX'(1);
        end
      end
      default: begin
        state_d     = ST_SWEEP;
        sweep_idx_d = '0;
      end
    endcase
  end

  l2_lru_update #(
    .ASSOC (ASSOC)
  ) u_update (
    .ranks_i (rank_mem_q[req_indx]),
    .op      (req_op),
    .way     (req_way),
    .ranks_o (upd_ranks),
    .victim  (victim)
  );

  // Write-back happens at the accept edge, so a back-to-back request to the
  // same set reads the updated ranks straight from the array.
  always_comb begin
    for (int i = 0; i < ASSOC; i++) init_ranks[i] = TYP_RU_NUM'(i);
    rank_mem_d = rank_mem_q;
    if (sweep_wr)    rank_mem_d[sweep_idx_q] = init_ranks;
    else if (accept) rank_mem_d[req_indx]    = upd_ranks;
  end

  always_comb begin
    rsp_valid_d = accept;
    rsp_way_d   = rsp_way_q;
    if (accept) rsp_way_d = (req_op == VICTIM) ? victim : req_way;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SWEEP;
      sweep_idx_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_way_q   <= '0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_way_q   <= rsp_way_d;
    end
  end

  always_ff @(posedge clk) begin
    rank_mem_q <= rank_mem_d;
  end

`ifdef L2_LRU_PERF_CNT_EN
  logic [31:0] touch_cnt_q, touch_cnt_d;
  logic [31:0] victim_cnt_q, victim_cnt_d;

  always_comb begin
    touch_cnt_d  = touch_cnt_q;
    victim_cnt_d = victim_cnt_q;
    if (clr) begin
      touch_cnt_d  = '0;
      victim_cnt_d = '0;
    end else if (accept) begin
      if (req_op == TOUCH && touch_cnt_q != 32'hFFFF_FFFF)
        touch_cnt_d = touch_cnt_q + 32'd1;
      if (req_op == VICTIM && victim_cnt_q != 32'hFFFF_FFFF)
        victim_cnt_d = victim_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      touch_cnt_q  <= '0;
      victim_cnt_q <= '0;
    end else begin
      touch_cnt_q  <= touch_cnt_d;
      victim_cnt_q <= victim_cnt_d;
    end
  end

  assign touch_cnt  = touch_cnt_q;
  assign victim_cnt = victim_cnt_q;
`endif

endmodule

// File: tb/tb_l2_lru_tracker.sv
// Self-checking bench for l2_lru_tracker (ASSOC=8, NUM_SETS=16): directed vector
// table, reset/clr sequences, then random traffic against a recency-order model.
module tb_l2_lru_tracker;
  import l2cpkg::*;

  localparam int SETS = 16;
  localparam int WAYS = 8;

  logic      clk = 1'b0;
  logic      rst, req_valid, clr;
  logic      req_ready, rsp_valid, busy;
  TYP_LRU_OP req_op;
  TYP_INDX   req_indx;
  TYP_RU_NUM req_way;
  TYP_RU_NUM rsp_way;
`ifdef L2_LRU_PERF_CNT_EN
  logic [31:0] touch_cnt, victim_cnt;
`endif

  l2_lru_tracker #(
    .NUM_SETS (SETS),
    .ASSOC    (WAYS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_indx   (req_indx),
    .req_way    (req_way),
    .rsp_valid  (rsp_valid),
    .rsp_way    (rsp_way),
    .clr        (clr),
    .busy       (busy)
`ifdef L2_LRU_PERF_CNT_EN
    ,
    .touch_cnt  (touch_cnt),
    .victim_cnt (victim_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_touch = 0;
  int exp_victim = 0;

  // Each set's ways ordered from least to most recently used.
  int lru_q [SETS][$];

  typedef struct {
    int op;
    int s;
    int w;
    int exp;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  function automatic void model_init();
    for (int s = 0; s < SETS; s++) begin
      lru_q[s].delete();
      for (int w = 0; w < WAYS; w++) lru_q[s].push_back(w);
    end
  endfunction

  function automatic void model_remove(input int s, input int w);
    for (int k = 0; k < lru_q[s].size(); k++) begin
      if (lru_q[s][k] == w) begin
        lru_q[s].delete(k);
        break;
      end
    end
  endfunction

  function automatic int model_apply(input int op, input int s, input int w);
    int r;
    r = w;
    case (op)
      0: begin model_remove(s, w); lru_q[s].push_back(w); end
      1: r = lru_q[s][0];
      2: begin model_remove(s, w); lru_q[s].push_front(w); end
      default: ;
    endcase
    return r;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input int op, input int s, input int w, input bit use_model,
                        input int tab_exp, input string name);
    int m;
    logic [1:0] op2;
    m = model_apply(op, s, w);
    op2 = op[1:0];
    req_valid = 1'b1;
    req_op    = TYP_LRU_OP'(op2);
    req_indx  = TYP_INDX'(s);
    req_way   = TYP_RU_NUM'(w);
    #1;
    chk({name, " req_ready"}, 32'(req_ready), 32'd1);
    if (op == 0) exp_touch++;
    if (op == 1) exp_victim++;
    cycle();
    req_valid = 1'b0;
    chk({name, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({name, " rsp_way"}, 32'(rsp_way), use_model ? 32'(m) : 32'(tab_exp));
  endtask

  task automatic wait_sweep(input string name);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      cycle();
    end
    chk({name, " busy cycles"}, 32'(n), 32'd16);
    model_init();
    exp_touch  = 0;
    exp_victim = 0;
  endtask

`ifdef L2_LRU_PERF_CNT_EN
  task automatic chk_cnt(input string name);
    chk({name, " touch_cnt"}, touch_cnt, 32'(exp_touch));
    chk({name, " victim_cnt"}, victim_cnt, 32'(exp_victim));
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; clr = 1'b0; req_valid = 1'b0;
    req_op = TOUCH; req_indx = '0; req_way = '0;
    model_init();

    cycle();
    cycle();
    chk("reset busy", 32'(busy), 32'd1);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_way", 32'(rsp_way), 32'd0);
    rst = 1'b0;
    wait_sweep("reset");
`ifdef L2_LRU_PERF_CNT_EN
    chk_cnt("after reset");
`endif

    // op: 0 TOUCH, 1 VICTIM, 2 INVAL, 3 reserved; all issued back-to-back
    vecs.push_back('{1, 3, 0, 0});
    for (int w = 0; w < 8; w++) vecs.push_back('{0, 5, w, w});
    vecs.push_back('{1, 5, 4, 0});
    vecs.push_back('{0, 5, 0, 0});
    vecs.push_back('{1, 5, 0, 1});
    vecs.push_back('{0, 5, 0, 0});
    vecs.push_back('{1, 5, 0, 1});
    vecs.push_back('{2, 2, 6, 6});
    vecs.push_back('{1, 2, 0, 6});
    vecs.push_back('{2, 2, 6, 6});
    vecs.push_back('{1, 2, 0, 6});
    vecs.push_back('{0, 2, 6, 6});
    vecs.push_back('{1, 2, 0, 0});
    vecs.push_back('{0, 2, 0, 0});
    vecs.push_back('{1, 2, 0, 1});
    vecs.push_back('{3, 2, 4, 4});
    vecs.push_back('{1, 2, 0, 1});
    vecs.push_back('{2, 9, 3, 3});
    vecs.push_back('{2, 9, 5, 5});
    vecs.push_back('{1, 9, 0, 5});
    vecs.push_back('{0, 7, 3, 3});
    vecs.push_back('{1, 7, 0, 0});
    vecs.push_back('{0, 7, 0, 0});
    vecs.push_back('{1, 7, 0, 1});
    for (int i = 0; i < vecs.size(); i++)
      do_req(vecs[i].op, vecs[i].s, vecs[i].w, 1'b0, vecs[i].exp, $sformatf("vec%0d", i));
    cycle();
    chk("idle after vectors rsp_valid", 32'(rsp_valid), 32'd0);
`ifdef L2_LRU_PERF_CNT_EN
    chk_cnt("after vectors");
`endif

    // clr together with a request, then a second clr at sweep index 9
    clr = 1'b1; req_valid = 1'b1; req_op = VICTIM; req_indx = TYP_INDX'(5);
    #1;
    chk("clr+req req_ready", 32'(req_ready), 32'd0);
    cycle();
    clr = 1'b0; req_valid = 1'b0;
    chk("clr+req rsp_valid", 32'(rsp_valid), 32'd0);
    chk("clr busy", 32'(busy), 32'd1);
    for (int i = 0; i < 9; i++) cycle();
    chk("sweep idx9 busy", 32'(busy), 32'd1);
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    wait_sweep("clr restart");
`ifdef L2_LRU_PERF_CNT_EN
    chk_cnt("after clr");
`endif
    do_req(1, 5, 0, 1'b1, 0, "victim after clr");

    // rst alongside a request discards its response
    do_req(0, 1, 5, 1'b1, 0, "touch before rst");
    rst = 1'b1; req_valid = 1'b1; req_op = TOUCH; req_indx = TYP_INDX'(1); req_way = TYP_RU_NUM'(6);
    cycle();
    rst = 1'b0; req_valid = 1'b0;
    chk("rst+req rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst+req rsp_way", 32'(rsp_way), 32'd0);
    wait_sweep("rst with req");

    // rst in the middle of a sweep
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    wait_sweep("rst mid-sweep");

    for (int it = 0; it < 400; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        clr = 1'b1;
        req_valid = 1'($urandom_range(0, 1));
        #1;
        chk("rand clr req_ready", 32'(req_ready), 32'd0);
        cycle();
        clr = 1'b0; req_valid = 1'b0;
        chk("rand clr rsp_valid", 32'(rsp_valid), 32'd0);
        wait_sweep("rand clr");
      end else if (r < 15) begin
        req_valid = 1'b0;
        cycle();
        chk("rand idle rsp_valid", 32'(rsp_valid), 32'd0);
      end else begin
        do_req($urandom_range(0, 3), $urandom_range(0, SETS-1), $urandom_range(0, WAYS-1),
               1'b1, 0, $sformatf("rand%0d", it));
      end
    end
`ifdef L2_LRU_PERF_CNT_EN
    chk_cnt("after random");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
